// File: rtl/xbram_sm_scheduler.sv
// Burst reader: streams X BRAM words to the SM check engine via a credit FIFO.
// Ports: start/base_addr/length in, xb_* BRAM port, sm_* engine handshake, busy/done/timeout_err.
module xbram_sm_scheduler #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] length,
  output logic          xb_en,
  output logic          xb_we,
  output logic [AW-1:0] xb_addr,
  input  logic [DW-1:0] xb_dout,
  output logic          sm_start,
  output logic [DW-1:0] sm_data,
  output logic          sm_valid,
  input  logic          sm_ready,
  input  logic          sm_out,
  output logic          busy,
  output logic          done,
  output logic          timeout_err
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0]     addr;
  logic [AW-1:0]     len_q;
  logic [AW-1:0]     issued;
  logic [RD_LAT-1:0] vpipe;
  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [CW-1:0]     count;
  logic [TW-1:0]     tmr;
  logic              err;

  logic [OW-1:0] inflight;
  logic [OW-1:0] outstanding;
  logic          issue;
  logic          last_issue;
  logic          push;
  logic          pop;
  logic          drained;
  logic          tmo;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit counts reads still in the delay line plus words
  // already buffered, so a push never finds the FIFO full.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + OW'(vpipe[i]);
    end
  end

  assign outstanding = inflight + OW'(count);
  assign issue       = (state == S_ISSUE) &&
                       (outstanding < OW'(FIFO_DEPTH));
  assign last_issue  = issue && (issued == len_q - AW'(1));
  assign push        = vpipe[RD_LAT-1];
  assign pop         = sm_valid && sm_ready;
  assign drained     = (vpipe == '0) && (count == '0);
  assign tmo         = (state == S_WAIT) && !sm_out &&
                       (tmr == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = (length == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: if (last_issue) state_nx = S_DRAIN;
      S_DRAIN: if (drained) state_nx = S_WAIT;
      S_WAIT:  if (sm_out || tmo) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    xb_en       = issue;
    xb_we       = 1'b0;
    xb_addr     = addr;
    sm_start    = (state == S_ISSUE) || (state == S_DRAIN) ||
                  (state == S_WAIT);
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    sm_valid    = (count != '0);
    sm_data     = sm_valid ? mem[rptr] : '0;
    timeout_err = err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr   <= '0;
      len_q  <= '0;
      issued <= '0;
      err    <= 1'b0;
      vpipe  <= '0;
      tmr    <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        addr   <= base_addr;
        len_q  <= length;
        issued <= '0;
        err    <= 1'b0;
      end else if (issue) begin
        addr   <= addr + AW'(1);
        issued <= issued + AW'(1);
      end
      if (tmo) err <= 1'b1;
      vpipe[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vpipe[i] <= vpipe[i-1];
      end
      if (state == S_WAIT) tmr <= tmr + TW'(1);
      else                 tmr <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= xb_dout;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= nxt(wptr);
      if (pop)  rptr <= nxt(rptr);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_xbram_sm_scheduler.sv
// Directed bench for xbram_sm_scheduler with a behavioural BRAM and sink.
// Ports: drives start/base/length/sm_ready/sm_out/rst, observes all outputs.
module tb_xbram_sm_scheduler;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RD_LAT = 2;
  localparam int FD = 4;
  localparam int TO = 1024;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic          xb_en;
  logic          xb_we;
  logic [AW-1:0] xb_addr;
  logic [DW-1:0] xb_dout;
  logic          sm_start;
  logic [DW-1:0] sm_data;
  logic          sm_valid;
  logic          sm_ready = 1'b1;
  logic          sm_out = 1'b0;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  xbram_sm_scheduler #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT),
    .FIFO_DEPTH(FD), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .length(length),
    .xb_en(xb_en), .xb_we(xb_we), .xb_addr(xb_addr),
    .xb_dout(xb_dout), .sm_start(sm_start),
    .sm_data(sm_data), .sm_valid(sm_valid),
    .sm_ready(sm_ready), .sm_out(sm_out),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  // BRAM model: RD_LAT=2 register stages, word tagged per burst.
  logic [7:0]    tag = 8'h00;
  logic [DW-1:0] d1 = '0;
  logic [DW-1:0] d2 = '0;

  always @(posedge clk) begin
    d1 <= xb_en ? {tag, 14'h0, xb_addr} : 32'hDEAD_BEEF;
    d2 <= d1;
  end
  assign xb_dout = d2;

  int            cyc = 0;
  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] got_q[$];
  int            en_cyc[$];
  int            acc_cyc[$];
  int            ss_cnt = 0;
  int            done_cnt = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      if (xb_en) begin
        addr_q.push_back(xb_addr);
        en_cyc.push_back(cyc);
      end
      if (sm_valid && sm_ready) begin
        got_q.push_back(sm_data);
        acc_cyc.push_back(cyc);
      end
      if (sm_start) ss_cnt = ss_cnt + 1;
      if (done) done_cnt = done_cnt + 1;
    end
  end

  function automatic logic [DW-1:0] word(input logic [7:0] tg,
                                         input logic [AW-1:0] a);
    return {tg, 14'h0, a};
  endfunction

  task automatic chk(input string nm, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic clr();
    addr_q.delete();
    got_q.delete();
    en_cyc.delete();
    acc_cyc.delete();
    ss_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] b,
                          input logic [AW-1:0] l);
    @(posedge clk); #1;
    base_addr = b;
    length = l;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = ~b;
    length = 10'h3FF;
  endtask

  task automatic wait_done(input string nm, input int maxc);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic check_burst(input string nm,
                             input logic [AW-1:0] b,
                             input int n,
                             input logic [7:0] tg);
    logic [AW-1:0] a;
    chk({nm, "_naddr"}, 64'(addr_q.size()), 64'(n));
    chk({nm, "_nword"}, 64'(got_q.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      a = b + AW'(i);
      if (i < addr_q.size()) chk({nm, "_addr"}, 64'(addr_q[i]), 64'(a));
      if (i < got_q.size()) chk({nm, "_data"}, 64'(got_q[i]), 64'(word(tg, a)));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dlt;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs",
        64'({busy, done, xb_en, xb_we, sm_start, sm_valid,
             timeout_err, xb_addr, sm_data}), 64'd0);
    rst = 1'b1;

    // basic burst, full throughput
    clr();
    tag = 8'h11;
    sm_ready = 1'b1;
    sm_out = 1'b1;
    do_start(10'h010, 10'd8);
    chk("b1_busy", 64'(busy), 64'd1);
    chk("b1_sm_start", 64'(sm_start), 64'd1);
    wait_done("b1", 60);
    @(posedge clk); #1;
    chk("b1_done_pulse", 64'(done), 64'd0);
    chk("b1_busy_after", 64'(busy), 64'd0);
    chk("b1_done_cnt", 64'(done_cnt), 64'd1);
    chk("b1_we", 64'(xb_we), 64'd0);
    check_burst("b1", 10'h010, 8, 8'h11);
    if (en_cyc.size() == 8)
      chk("b1_en_consec", 64'(en_cyc[7] - en_cyc[0]), 64'd7);
    if (acc_cyc.size() == 8)
      chk("b1_acc_consec", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);

    // back-pressure mid-burst
    clr();
    tag = 8'h22;
    do_start(10'h100, 10'd8);
    for (int k = 0; k < 30; k++) begin
      if (got_q.size() >= 2) break;
      @(posedge clk); #1;
    end
    chk("st_reach2", 64'(got_q.size()), 64'd2);
    sm_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("st_outstanding", 64'(en_cyc.size() - got_q.size()), 64'(FD));
    chk("st_en_low", 64'(xb_en), 64'd0);
    chk("st_valid", 64'(sm_valid), 64'd1);
    chk("st_head", 64'(sm_data), 64'(word(8'h22, 10'h102)));
    @(posedge clk); #1;
    chk("st_hold", 64'(sm_data), 64'(word(8'h22, 10'h102)));
    sm_ready = 1'b1;
    wait_done("st", 60);
    check_burst("st", 10'h100, 8, 8'h22);

    // address wrap
    clr();
    tag = 8'h33;
    do_start(10'h3FE, 10'd4);
    wait_done("wr", 60);
    check_burst("wr", 10'h3FE, 4, 8'h33);

    // zero length
    @(posedge clk); #1;
    clr();
    do_start(10'h123, 10'd0);
    chk("z_done", 64'(done), 64'd1);
    @(posedge clk); #1;
    chk("z_done_off", 64'(done), 64'd0);
    chk("z_busy", 64'(busy), 64'd0);
    chk("z_no_en", 64'(en_cyc.size()), 64'd0);
    chk("z_no_sm_start", 64'(ss_cnt), 64'd0);

    // timeout
    clr();
    tag = 8'h44;
    sm_out = 1'b0;
    do_start(10'h020, 10'd2);
    wait_done("to", TO + 60);
    chk("to_err", 64'(timeout_err), 64'd1);
    if (acc_cyc.size() == 2) begin
      dlt = cyc - acc_cyc[1];
      chk("to_wait_len", 64'(dlt), 64'(TO + 1));
    end
    repeat (3) @(posedge clk);
    #1;
    chk("to_sticky", 64'(timeout_err), 64'd1);
    chk("to_idle", 64'(busy), 64'd0);
    check_burst("to", 10'h020, 2, 8'h44);
    clr();
    tag = 8'h55;
    sm_out = 1'b1;
    do_start(10'h030, 10'd1);
    chk("to_cleared", 64'(timeout_err), 64'd0);
    wait_done("rs", 60);
    check_burst("rs", 10'h030, 1, 8'h55);

    // reset with reads in flight
    clr();
    tag = 8'h66;
    sm_ready = 1'b0;
    do_start(10'h040, 10'd8);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rr_outputs",
        64'({busy, done, xb_en, xb_we, sm_start, sm_valid,
             timeout_err, xb_addr, sm_data}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    clr();
    tag = 8'h77;
    sm_ready = 1'b1;
    sm_out = 1'b1;
    do_start(10'h080, 10'd3);
    wait_done("rr", 60);
    @(posedge clk); #1;
    check_burst("rr", 10'h080, 3, 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
